hazard_scoreboard: RTL and testbench

//  ID-stage producer side of the forwarding interface in the 5-stage RISC-V pipeline.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue signals into the hazard scoreboard and the stall/forwarding
// controls it returns. Signal names match the block's pin names.
interface hazard_scoreboard_if;
    logic       ID_valid_i;
    logic [4:0] ID_RS1addr_i;
    logic [4:0] ID_RS2addr_i;
    logic       ID_RS1use_i;
    logic       ID_RS2use_i;
    logic [4:0] ID_RDaddr_i;
    logic       ID_RegWrite_i;
    logic       ID_MemRead_i;
    logic       ID_Mul_i;
    logic       Flush_i;
    logic       Stall_o;
    logic       Bubble_o;
    logic       MulBusy_o;
    logic       EX_MEM_RegWrite_o;
    logic [4:0] EX_MEM_RDaddr_o;
    logic       MEM_WB_RegWrite_o;
    logic [4:0] MEM_WB_RDaddr_o;

    // ID stage side: presents the instruction, consumes stall/forwarding info.
    modport master (
        output ID_valid_i, ID_RS1addr_i, ID_RS2addr_i, ID_RS1use_i, ID_RS2use_i,
               ID_RDaddr_i, ID_RegWrite_i, ID_MemRead_i, ID_Mul_i, Flush_i,
        input  Stall_o, Bubble_o, MulBusy_o, EX_MEM_RegWrite_o, EX_MEM_RDaddr_o,
               MEM_WB_RegWrite_o, MEM_WB_RDaddr_o
    );

    // Scoreboard side.
    modport slave (
        input  ID_valid_i, ID_RS1addr_i, ID_RS2addr_i, ID_RS1use_i, ID_RS2use_i,
               ID_RDaddr_i, ID_RegWrite_i, ID_MemRead_i, ID_Mul_i, Flush_i,
        output Stall_o, Bubble_o, MulBusy_o, EX_MEM_RegWrite_o, EX_MEM_RDaddr_o,
               MEM_WB_RegWrite_o, MEM_WB_RDaddr_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows the destination writes in EX/MEM/WB, detects
// load-use hazards, holds EX for multi-cycle MULs and drives the forwarding
// unit's EX/MEM and MEM/WB RegWrite/RDaddr pairs.
module hazard_scoreboard #(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned CNT_W       = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    hazard_scoreboard_if.slave bus
);

    typedef enum logic {StIdle, StBusy} stateT;

    // EX needs memRead for load-use detection; downstream only forwarding data matters.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
    } exEntryT;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regWrite;
    } fwdEntryT;

    localparam logic [CNT_W-1:0] MulLoad  = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam bit               MulMulti = (MUL_LATENCY > 1);

    stateT            state;
    logic [CNT_W-1:0] mulCnt;
    logic             mulBusy;
    exEntryT          exEntry;
    exEntryT          idEntry;
    fwdEntryT         memEntry;
    fwdEntryT         wbEntry;
    logic             loadUse;
    logic             stall;
    logic             bubble;
    logic             mulIssue;

    // Hazard detection, stall/bubble decode and the entry ID would push into EX.
    always_comb begin
        loadUse = exEntry.valid & exEntry.memRead & exEntry.regWrite & bus.ID_valid_i &
                  ((bus.ID_RS1use_i & (bus.ID_RS1addr_i == exEntry.rd)) |
                   (bus.ID_RS2use_i & (bus.ID_RS2addr_i == exEntry.rd)));
        stall  = 1'b0;
        bubble = 1'b0;
        if (rst_i) begin
            stall  = 1'b0;
            bubble = 1'b0;
        end else if (state == StBusy) begin
            // ID is frozen; any flush is re-presented once the MUL drains.
            stall  = 1'b1;
            bubble = 1'b0;
        end else begin
            stall  = loadUse & ~bus.Flush_i;
            bubble = loadUse | bus.Flush_i;
        end
        idEntry = '0;
        if (bus.ID_valid_i && !bubble) begin
            idEntry.valid    = 1'b1;
            idEntry.rd       = bus.ID_RDaddr_i;
            // x0 is never a real producer, so never let it forward or interlock.
            idEntry.regWrite = bus.ID_RegWrite_i & (bus.ID_RDaddr_i != 5'd0);
            idEntry.memRead  = bus.ID_MemRead_i;
        end
        mulIssue = idEntry.valid & bus.ID_Mul_i;
    end

    // Multiplier FSM and shadow pipeline advance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= StIdle;
            mulCnt   <= '0;
            mulBusy  <= 1'b0;
            exEntry  <= '0;
            memEntry <= '0;
            wbEntry  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    wbEntry  <= memEntry;
                    memEntry <= fwdEntryT'({exEntry.valid, exEntry.rd, exEntry.regWrite});
                    exEntry  <= idEntry;
                    if (mulIssue && MulMulti) begin
                        state   <= StBusy;
                        mulCnt  <= MulLoad;
                        mulBusy <= 1'b1;
                    end
                end
                StBusy: begin
                    // EX holds the MUL; MEM fills with bubbles while WB drains.
                    wbEntry  <= memEntry;
                    memEntry <= '0;
                    if (mulCnt <= CntOne) begin
                        state   <= StIdle;
                        mulCnt  <= '0;
                        mulBusy <= 1'b0;
                    end else begin
                        mulCnt <= mulCnt - CntOne;
                    end
                end
            endcase
        end
    end

    assign bus.Stall_o           = stall;
    assign bus.Bubble_o          = bubble;
    assign bus.MulBusy_o         = mulBusy;
    assign bus.EX_MEM_RegWrite_o = memEntry.valid & memEntry.regWrite;
    assign bus.EX_MEM_RDaddr_o   = memEntry.rd;
    assign bus.MEM_WB_RegWrite_o = wbEntry.valid & wbEntry.regWrite;
    assign bus.MEM_WB_RDaddr_o   = wbEntry.rd;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, x0 loads, multi-cycle MUL,
// flush priority, reset during MUL, independent stream, single-cycle MUL.
module tb_hazard_scoreboard;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    hazard_scoreboard_if bus ();
    hazard_scoreboard_if bus1 ();

    hazard_scoreboard #(.MUL_LATENCY(3), .CNT_W(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    hazard_scoreboard #(.MUL_LATENCY(1), .CNT_W(4)) dut1 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mul);
        bus.ID_valid_i    = v;
        bus.ID_RS1addr_i  = rs1;
        bus.ID_RS2addr_i  = rs2;
        bus.ID_RS1use_i   = u1;
        bus.ID_RS2use_i   = u2;
        bus.ID_RDaddr_i   = rd;
        bus.ID_RegWrite_i = rw;
        bus.ID_MemRead_i  = mr;
        bus.ID_Mul_i      = mul;
    endtask

    task automatic nop();
        setId(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        bus.Flush_i = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        nop();
        bus.Flush_i        = 1'b1;
        bus1.ID_valid_i    = 1'b0;
        bus1.ID_RS1addr_i  = 5'd0;
        bus1.ID_RS2addr_i  = 5'd0;
        bus1.ID_RS1use_i   = 1'b0;
        bus1.ID_RS2use_i   = 1'b0;
        bus1.ID_RDaddr_i   = 5'd0;
        bus1.ID_RegWrite_i = 1'b0;
        bus1.ID_MemRead_i  = 1'b0;
        bus1.ID_Mul_i      = 1'b0;
        bus1.Flush_i       = 1'b0;

        // Reset before any clock edge: everything low, even with Flush_i high.
        #1 rst = 1'b1;
        #2;
        chk("rst_stall", 32'(bus.Stall_o), 0);
        chk("rst_bubble", 32'(bus.Bubble_o), 0);
        chk("rst_mulbusy", 32'(bus.MulBusy_o), 0);
        chk("rst_exmem_rw", 32'(bus.EX_MEM_RegWrite_o), 0);
        chk("rst_memwb_rw", 32'(bus.MEM_WB_RegWrite_o), 0);
        tick();
        tick();
        rst         = 1'b0;
        bus.Flush_i = 1'b0;

        // 1. lw x5 ; add x6,x5,x7
        setId(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1 chk("t1_lw_nostall", 32'(bus.Stall_o), 0);
        tick();
        setId(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("t1_lu_stall", 32'(bus.Stall_o), 1);
        chk("t1_lu_bubble", 32'(bus.Bubble_o), 1);
        tick();
        #1 chk("t1_release", 32'(bus.Stall_o), 0);
        chk("t1_exmem_rd", 32'(bus.EX_MEM_RDaddr_o), 5);
        chk("t1_exmem_rw", 32'(bus.EX_MEM_RegWrite_o), 1);
        tick();
        nop();
        #1 chk("t1_memwb_rd", 32'(bus.MEM_WB_RDaddr_o), 5);
        chk("t1_exmem_bubble", 32'(bus.EX_MEM_RegWrite_o), 0);
        tick();
        chk("t1_add_exmem_rd", 32'(bus.EX_MEM_RDaddr_o), 6);
        chk("t1_add_exmem_rw", 32'(bus.EX_MEM_RegWrite_o), 1);
        drain();

        // 2. lw x0 ; add using x0
        setId(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("t2_x0_stall", 32'(bus.Stall_o), 0);
        chk("t2_x0_bubble", 32'(bus.Bubble_o), 0);
        tick();
        nop();
        #1 chk("t2_x0_exmem_rw", 32'(bus.EX_MEM_RegWrite_o), 0);
        drain();

        // 3. MUL x9, latency 3, with a flush offered while busy
        setId(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        #1 chk("t3_issue_busy", 32'(bus.MulBusy_o), 0);
        tick();
        setId(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        bus.Flush_i = 1'b1;
        #1 chk("t3_b1_busy", 32'(bus.MulBusy_o), 1);
        chk("t3_b1_stall", 32'(bus.Stall_o), 1);
        chk("t3_b1_flush_ign", 32'(bus.Bubble_o), 0);
        tick();
        bus.Flush_i = 1'b0;
        #1 chk("t3_b2_busy", 32'(bus.MulBusy_o), 1);
        chk("t3_b2_stall", 32'(bus.Stall_o), 1);
        chk("t3_b2_mem_bub", 32'(bus.EX_MEM_RegWrite_o), 0);
        tick();
        chk("t3_done_busy", 32'(bus.MulBusy_o), 0);
        chk("t3_done_stall", 32'(bus.Stall_o), 0);
        chk("t3_mem_bub2", 32'(bus.EX_MEM_RegWrite_o), 0);
        tick();
        nop();
        #1 chk("t3_exmem_rd", 32'(bus.EX_MEM_RDaddr_o), 9);
        chk("t3_exmem_rw", 32'(bus.EX_MEM_RegWrite_o), 1);
        drain();

        // 4. load-use and flush together: flush wins
        setId(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        bus.Flush_i = 1'b1;
        #1 chk("t4_stall", 32'(bus.Stall_o), 0);
        chk("t4_bubble", 32'(bus.Bubble_o), 1);
        tick();
        nop();
        bus.Flush_i = 1'b0;
        tick();
        chk("t4_ex_inv_rw", 32'(bus.EX_MEM_RegWrite_o), 0);
        chk("t4_ex_inv_rd", 32'(bus.EX_MEM_RDaddr_o), 0);
        chk("t4_lw_memwb", 32'(bus.MEM_WB_RDaddr_o), 5);
        drain();

        // 5. reset while busy with counter at 1
        setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        setId(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        tick();
        setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        #1 chk("t5_pre_busy", 32'(bus.MulBusy_o), 1);
        chk("t5_pre_memwb", 32'(bus.MEM_WB_RDaddr_o), 3);
        rst = 1'b1;
        #1 chk("t5_rst_busy", 32'(bus.MulBusy_o), 0);
        chk("t5_rst_stall", 32'(bus.Stall_o), 0);
        chk("t5_rst_exmem_rw", 32'(bus.EX_MEM_RegWrite_o), 0);
        chk("t5_rst_exmem_rd", 32'(bus.EX_MEM_RDaddr_o), 0);
        chk("t5_rst_memwb_rw", 32'(bus.MEM_WB_RegWrite_o), 0);
        chk("t5_rst_memwb_rd", 32'(bus.MEM_WB_RDaddr_o), 0);
        tick();
        rst = 1'b0;
        nop();
        #1 chk("t5_post_busy", 32'(bus.MulBusy_o), 0);
        tick();
        chk("t5_mul_gone", 32'(bus.EX_MEM_RegWrite_o), 0);
        drain();

        // 6. independent add stream x1..x4
        for (int i = 1; i <= 7; i++) begin
            if (i <= 4) setId(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'(i), 1'b1, 1'b0, 1'b0);
            else nop();
            #1 chk("t6_stall", 32'(bus.Stall_o), 0);
            if (i >= 3 && i <= 6) chk("t6_exmem_rd", 32'(bus.EX_MEM_RDaddr_o), 32'(i - 2));
            if (i >= 4) chk("t6_memwb_rd", 32'(bus.MEM_WB_RDaddr_o), 32'(i - 3));
            tick();
        end

        // Single-cycle MUL never enters the busy state.
        bus1.ID_valid_i    = 1'b1;
        bus1.ID_RDaddr_i   = 5'd9;
        bus1.ID_RegWrite_i = 1'b1;
        bus1.ID_Mul_i      = 1'b1;
        tick();
        bus1.ID_valid_i = 1'b0;
        bus1.ID_Mul_i   = 1'b0;
        #1 chk("l1_busy", 32'(bus1.MulBusy_o), 0);
        chk("l1_stall", 32'(bus1.Stall_o), 0);
        tick();
        chk("l1_exmem_rd", 32'(bus1.EX_MEM_RDaddr_o), 9);
        chk("l1_exmem_rw", 32'(bus1.EX_MEM_RegWrite_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
